// File: rtl/spi_ro_monitor_if.sv
// Output stream of spi_ro_monitor: one captured FIFO entry per valid/ready handshake.
interface spi_ro_monitor_if #(
  parameter int unsigned DWIDTH = 32
);
  localparam int unsigned NBW = $clog2(DWIDTH + 1);

  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_master_data;
  logic [DWIDTH-1:0] out_slave_data;
  logic [NBW-1:0]    out_nbits;
  logic              out_last;

  modport master (
    output out_valid, out_master_data, out_slave_data, out_nbits, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_master_data, out_slave_data, out_nbits, out_last,
    output out_ready
  );
endinterface

// File: rtl/spi_ro_monitor.sv
// Passive SPI bus monitor: captures MOSI/MISO words in any SPI mode into a first-word-fall-through FIFO.
// Optional SPI_RO_MONITOR_TIMESTAMP_EN tags every entry with the clk count latched at the frame's ss_n fall.
module spi_ro_monitor #(
  parameter int unsigned DWIDTH        = 32,
  parameter int unsigned BITCOUNTWIDTH = 12,
  parameter bit          CPOL          = 1'b1,
  parameter bit          CPHA          = 1'b0,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               spi_ss_n,
  input  logic                               spi_sclk,
  input  logic                               spi_mosi,
  input  logic                               spi_miso,
  spi_ro_monitor_if.master                   stream,
  output logic [BITCOUNTWIDTH-1:0]           frame_bits,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               overflow,
  input  logic                               overflow_clr
`ifdef SPI_RO_MONITOR_TIMESTAMP_EN
  ,
  output logic [31:0]                        out_timestamp
`endif
);
  localparam int unsigned NBW = $clog2(DWIDTH + 1);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LW  = $clog2(FIFO_DEPTH + 1);
  localparam bit SAMPLE_RISE  = (CPOL == CPHA);

  typedef struct packed {
`ifdef SPI_RO_MONITOR_TIMESTAMP_EN
    logic [31:0]       ts;
`endif
    logic [DWIDTH-1:0] m;
    logic [DWIDTH-1:0] s;
    logic [NBW-1:0]    nbits;
    logic              last;
  } entry_t;

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE, FLUSH} state_t;

  state_t state, state_nx;

  // Synchronisers reset low so ss_n must be seen high on the pin before a frame can open.
  logic [3:0] sync1, sync2, hist;
  logic       ss_s, ss_h, sclk_s, sclk_h, mosi_d, miso_d;
  logic       sample, ss_fall, ss_rise;

  always_ff @(posedge clk or negedge reset_n) begin : sync_chain
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= {spi_ss_n, spi_sclk, spi_mosi, spi_miso};
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign ss_s    = sync2[3];
  assign ss_h    = hist[3];
  assign sclk_s  = sync2[2];
  assign sclk_h  = hist[2];
  assign mosi_d  = hist[1];
  assign miso_d  = hist[0];
  assign sample  = SAMPLE_RISE ? (sclk_s & ~sclk_h) : (~sclk_s & sclk_h);
  assign ss_fall = ss_h & ~ss_s;
  assign ss_rise = ~ss_h & ss_s;

  logic [DWIDTH-1:0]        sh_m, sh_s, sh_m_nx, sh_s_nx, m_cur, s_cur;
  logic [NBW-1:0]           bit_cnt, bit_nx, cnt_cur;
  logic [BITCOUNTWIDTH-1:0] frame_cnt, frame_inc, frame_cur;
  logic                     word_done;

  // Next shift values; the partial word at frame end includes a coincident sample.
  always_comb begin : shift_calc
    sh_m_nx   = {sh_m[DWIDTH-2:0], mosi_d};
    sh_s_nx   = {sh_s[DWIDTH-2:0], miso_d};
    bit_nx    = bit_cnt + NBW'(1);
    frame_inc = (frame_cnt == '1) ? frame_cnt : frame_cnt + BITCOUNTWIDTH'(1);
    word_done = sample && (bit_nx == NBW'(DWIDTH));
    cnt_cur   = sample ? bit_nx : bit_cnt;
    m_cur     = sample ? sh_m_nx : sh_m;
    s_cur     = sample ? sh_s_nx : sh_s;
    frame_cur = sample ? frame_inc : frame_cnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin : state_reg
    if (!reset_n) state <= WAIT_IDLE;
    else          state <= state_nx;
  end

  always_comb begin : next_state
    state_nx = state;
    case (state)
      WAIT_IDLE: if (ss_s) state_nx = IDLE;
      IDLE:      if (ss_fall) state_nx = ACTIVE;
      ACTIVE:    if (ss_rise) state_nx = word_done ? FLUSH : IDLE;
      FLUSH:     state_nx = IDLE;
      default:   state_nx = WAIT_IDLE;
    endcase
  end

  logic                     clr, shift, push, set_fbits;
  logic [BITCOUNTWIDTH-1:0] fbits_val;
  entry_t                   push_e;
`ifdef SPI_RO_MONITOR_TIMESTAMP_EN
  logic [31:0]              ts_cnt, ts_frame;
`endif

  always_comb begin : fsm_out
    clr       = 1'b0;
    shift     = 1'b0;
    push      = 1'b0;
    set_fbits = 1'b0;
    fbits_val = frame_cnt;
    push_e    = '0;
`ifdef SPI_RO_MONITOR_TIMESTAMP_EN
    push_e.ts = ts_frame;
`endif
    case (state)
      IDLE: clr = ss_fall;
      ACTIVE: begin
        shift = sample;
        if (word_done) begin
          push         = 1'b1;
          push_e.m     = sh_m_nx;
          push_e.s     = sh_s_nx;
          push_e.nbits = NBW'(DWIDTH);
        end else if (ss_rise && (cnt_cur != '0)) begin
          push         = 1'b1;
          push_e.m     = m_cur;
          push_e.s     = s_cur;
          push_e.nbits = cnt_cur;
          push_e.last  = 1'b1;
          set_fbits    = 1'b1;
          fbits_val    = frame_cur;
        end else if (ss_rise && (frame_cur != '0)) begin
          push        = 1'b1;
          push_e.last = 1'b1;
          set_fbits   = 1'b1;
          fbits_val   = frame_cur;
        end
      end
      FLUSH: begin
        push        = 1'b1;
        push_e.last = 1'b1;
        set_fbits   = 1'b1;
      end
      default: ;
    endcase
  end

  // Word and frame capture; a completed word clears the shifters so partials stay right-aligned.
  always_ff @(posedge clk or negedge reset_n) begin : capture
    if (!reset_n) begin
      sh_m       <= '0;
      sh_s       <= '0;
      bit_cnt    <= '0;
      frame_cnt  <= '0;
      frame_bits <= '0;
    end else begin
      if (clr) begin
        sh_m      <= '0;
        sh_s      <= '0;
        bit_cnt   <= '0;
        frame_cnt <= '0;
      end else if (shift) begin
        frame_cnt <= frame_inc;
        if (word_done) begin
          sh_m    <= '0;
          sh_s    <= '0;
          bit_cnt <= '0;
        end else begin
          sh_m    <= sh_m_nx;
          sh_s    <= sh_s_nx;
          bit_cnt <= bit_nx;
        end
      end
      if (set_fbits) frame_bits <= fbits_val;
    end
  end

`ifdef SPI_RO_MONITOR_TIMESTAMP_EN
  always_ff @(posedge clk or negedge reset_n) begin : timestamp
    if (!reset_n) begin
      ts_cnt   <= '0;
      ts_frame <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (clr) ts_frame <= ts_cnt;
    end
  end
`endif

  entry_t         mem [FIFO_DEPTH];
  entry_t         head_q, head_nx;
  logic [AW-1:0]  wr_ptr, rd_ptr, rd_nx;
  logic [LW-1:0]  level_nx;
  logic           valid_q, pop, push_ok, drop;

  // Head register is reloaded every cycle so out_valid follows a push into an empty FIFO by one cycle.
  always_comb begin : fifo_calc
    pop      = valid_q && stream.out_ready;
    push_ok  = push && (fifo_level < LW'(FIFO_DEPTH));
    drop     = push && !push_ok;
    rd_nx    = pop ? rd_ptr + AW'(1) : rd_ptr;
    level_nx = fifo_level + LW'(push_ok) - LW'(pop);
    head_nx  = (push_ok && (wr_ptr == rd_nx)) ? push_e : mem[rd_nx];
  end

  always_ff @(posedge clk) begin : fifo_mem
    if (push_ok) mem[wr_ptr] <= push_e;
  end

  always_ff @(posedge clk or negedge reset_n) begin : fifo_ctrl
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      valid_q    <= 1'b0;
      head_q     <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_nx;
      fifo_level <= level_nx;
      valid_q    <= (level_nx != '0);
      head_q     <= (level_nx != '0) ? head_nx : '0;
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  assign stream.out_valid       = valid_q;
  assign stream.out_master_data = head_q.m;
  assign stream.out_slave_data  = head_q.s;
  assign stream.out_nbits       = head_q.nbits;
  assign stream.out_last        = head_q.last;
`ifdef SPI_RO_MONITOR_TIMESTAMP_EN
  assign out_timestamp          = head_q.ts;
`endif
endmodule

// File: tb/tb_spi_ro_monitor.sv
// Bench for spi_ro_monitor: four instances (one per SPI mode) watch one shared bus against a scoreboard.
module tb_spi_ro_monitor;
  localparam int unsigned DW  = 8;
  localparam int unsigned NBW = $clog2(DW + 1);
  localparam int unsigned HP  = 3;
  localparam int unsigned ND  = 4;

  typedef struct packed {
    logic [DW-1:0]  m;
    logic [DW-1:0]  s;
    logic [NBW-1:0] nb;
    logic           last;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, ss_n, sclk_base, mosi, miso, ready, ovf_clr;

  logic           valid  [ND];
  logic           last_o [ND];
  logic [DW-1:0]  mdat   [ND];
  logic [DW-1:0]  sdat   [ND];
  logic [NBW-1:0] nb     [ND];
  logic [11:0]    fbits  [ND];
  logic [2:0]     lvl    [ND];
  logic           ovf    [ND];
`ifdef SPI_RO_MONITOR_TIMESTAMP_EN
  logic [31:0]    ts     [ND];
`endif

  // Instance g: CPOL/CPHA = 0/0, 1/1, 0/1, 1/0; the pin clock is the base clock with CPOL's idle level.
  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam bit P = (g == 1 || g == 3);
    localparam bit H = (g == 1 || g == 2);
    spi_ro_monitor_if #(.DWIDTH(DW)) bus ();
    assign bus.out_ready = ready;
    spi_ro_monitor #(
      .DWIDTH(DW), .BITCOUNTWIDTH(12), .CPOL(P), .CPHA(H), .FIFO_DEPTH(4)
    ) u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .spi_ss_n     (ss_n),
      .spi_sclk     (sclk_base ^ P),
      .spi_mosi     (mosi),
      .spi_miso     (miso),
      .stream       (bus),
      .frame_bits   (fbits[g]),
      .fifo_level   (lvl[g]),
      .overflow     (ovf[g]),
      .overflow_clr (ovf_clr)
`ifdef SPI_RO_MONITOR_TIMESTAMP_EN
      ,
      .out_timestamp(ts[g])
`endif
    );
    assign valid[g]  = bus.out_valid;
    assign last_o[g] = bus.out_last;
    assign mdat[g]   = bus.out_master_data;
    assign sdat[g]   = bus.out_slave_data;
    assign nb[g]     = bus.out_nbits;
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t exp_q [ND][$];
  logic stalled [ND];
  ent_t held [ND];
  int   ready_mode;
  int   tog;

  task automatic mon();
    ent_t cur;
    ent_t e;
    bit   have;
    for (int g = 0; g < ND; g++) begin
      cur = {mdat[g], sdat[g], nb[g], last_o[g]};
      if (stalled[g]) begin
        n_tests++;
        assert (valid[g] === 1'b1 && cur === held[g]) else begin
          n_fail++;
          $error("FAIL hold dut%0d got v=%b %h want v=1 %h", g, valid[g], cur, held[g]);
        end
      end
      if (valid[g] === 1'b1 && ready === 1'b1) begin
        n_tests++;
        have = (exp_q[g].size() != 0);
        e    = have ? exp_q[g].pop_front() : '0;
        assert (have && cur === e) else begin
          n_fail++;
          $error("FAIL entry dut%0d got %h want %h (expected pending=%0b)", g, cur, e, have);
        end
`ifdef SPI_RO_MONITOR_TIMESTAMP_EN
        n_tests++;
        assert (ts[g] !== 32'd0) else begin
          n_fail++;
          $error("FAIL timestamp dut%0d got %h want nonzero", g, ts[g]);
        end
`endif
      end
      stalled[g] = (valid[g] === 1'b1) && (ready === 1'b0);
      held[g]    = cur;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    case (ready_mode)
      0: ready = 1'b1;
      1: ready = 1'b0;
      default: begin
        tog++;
        if (tog == 3) begin
          tog   = 0;
          ready = ~ready;
        end
      end
    endcase
    mon();
  endtask

  task automatic chk(input string tag, input int g, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s dut%0d got %0h want %0h", tag, g, got, want);
    end
  endtask

  task automatic expect_e(input logic [DW-1:0] m, input logic [DW-1:0] s, input int nbv, input logic l);
    for (int g = 0; g < ND; g++) exp_q[g].push_back({m, s, NBW'(nbv), l});
  endtask

  // Data is held stable across both clock edges so every mode samples the same bit.
  task automatic send_bits(input logic [63:0] mo, input logic [63:0] mi, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = mo[i];
      miso = mi[i];
      repeat (HP) cyc();
      sclk_base = 1'b1;
      repeat (HP) cyc();
      sclk_base = 1'b0;
      repeat (HP) cyc();
    end
  endtask

  task automatic frame(input logic [63:0] mo, input logic [63:0] mi, input int n);
    ss_n = 1'b0;
    repeat (HP) cyc();
    send_bits(mo, mi, n);
    ss_n = 1'b1;
    repeat (HP) cyc();
  endtask

  task automatic chk_drained(input string tag);
    for (int g = 0; g < ND; g++) begin
      chk(tag, g, 64'(exp_q[g].size()), 64'd0);
      chk({tag, "_level"}, g, 64'(lvl[g]), 64'd0);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    ss_n       = 1'b1;
    sclk_base  = 1'b0;
    mosi       = 1'b0;
    miso       = 1'b0;
    ready      = 1'b1;
    ovf_clr    = 1'b0;
    ready_mode = 0;
    tog        = 0;
    for (int g = 0; g < ND; g++) begin
      stalled[g] = 1'b0;
      held[g]    = '0;
    end

    repeat (5) cyc();
    for (int g = 0; g < ND; g++) begin
      chk("rst_valid", g, 64'(valid[g]), 64'd0);
      chk("rst_data", g, {mdat[g], sdat[g], nb[g], last_o[g]}, 64'd0);
      chk("rst_level", g, 64'(lvl[g]), 64'd0);
      chk("rst_ovf", g, 64'(ovf[g]), 64'd0);
      chk("rst_fbits", g, 64'(fbits[g]), 64'd0);
    end
    reset_n = 1'b1;
    repeat (6) cyc();

    // Full byte then zero-length closing marker.
    expect_e(8'hA5, 8'h3C, 8, 1'b0);
    expect_e(8'h00, 8'h00, 0, 1'b1);
    frame(64'hA5, 64'h3C, 8);
    repeat (12) cyc();
    chk_drained("base_drained");
    for (int g = 0; g < ND; g++) chk("base_fbits", g, 64'(fbits[g]), 64'd8);

    // 12-bit frame: one full byte plus a right-aligned 4-bit tail.
    expect_e(8'hAB, 8'h5E, 8, 1'b0);
    expect_e(8'h0C, 8'h07, 4, 1'b1);
    frame(64'hABC, 64'h5E7, 12);
    repeat (12) cyc();
    chk_drained("part_drained");
    for (int g = 0; g < ND; g++) chk("part_fbits", g, 64'(fbits[g]), 64'd12);

    // Six bytes into a stalled 4-deep FIFO: only the first four survive.
    ready_mode = 1;
    expect_e(8'h11, 8'hEE, 8, 1'b0);
    expect_e(8'h22, 8'hDD, 8, 1'b0);
    expect_e(8'h33, 8'hCC, 8, 1'b0);
    expect_e(8'h44, 8'hBB, 8, 1'b0);
    frame(64'h1122_3344_5566, 64'hEEDD_CCBB_AA99, 48);
    repeat (8) cyc();
    for (int g = 0; g < ND; g++) begin
      chk("ovf_level", g, 64'(lvl[g]), 64'd4);
      chk("ovf_flag", g, 64'(ovf[g]), 64'd1);
      chk("ovf_valid", g, 64'(valid[g]), 64'd1);
    end
    ready_mode = 0;
    repeat (10) cyc();
    chk_drained("ovf_drained");
    for (int g = 0; g < ND; g++) chk("ovf_sticky", g, 64'(ovf[g]), 64'd1);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    for (int g = 0; g < ND; g++) chk("ovf_clr", g, 64'(ovf[g]), 64'd0);

    // Reset in mid-frame: the remainder of that frame must be ignored.
    reset_n = 1'b0;
    repeat (3) cyc();
    reset_n = 1'b1;
    repeat (3) cyc();
    ss_n = 1'b0;
    repeat (HP) cyc();
    send_bits(64'h16, 64'h09, 5);
    reset_n = 1'b0;
    repeat (3) cyc();
    for (int g = 0; g < ND; g++) chk("midrst_valid", g, 64'(valid[g]), 64'd0);
    reset_n = 1'b1;
    repeat (3) cyc();
    send_bits(64'hF0, 64'h0F, 8);
    ss_n = 1'b1;
    repeat (20) cyc();
    chk_drained("midrst_none");
    for (int g = 0; g < ND; g++) chk("midrst_fbits", g, 64'(fbits[g]), 64'd0);
    expect_e(8'h5A, 8'hC3, 8, 1'b0);
    expect_e(8'h00, 8'h00, 0, 1'b1);
    frame(64'h5A, 64'hC3, 8);
    repeat (12) cyc();
    chk_drained("midrst_next");
    for (int g = 0; g < ND; g++) chk("midrst_next_fbits", g, 64'(fbits[g]), 64'd8);

    // Four back-to-back words with out_ready toggling every 3 cycles.
    ready_mode = 2;
    tog        = 0;
    expect_e(8'hDE, 8'h01, 8, 1'b0);
    expect_e(8'hAD, 8'h23, 8, 1'b0);
    expect_e(8'hBE, 8'h45, 8, 1'b0);
    expect_e(8'hEF, 8'h67, 8, 1'b0);
    expect_e(8'h00, 8'h00, 0, 1'b1);
    frame(64'hDEAD_BEEF, 64'h0123_4567, 32);
    repeat (30) cyc();
    ready_mode = 0;
    repeat (10) cyc();
    chk_drained("bp_drained");
    for (int g = 0; g < ND; g++) begin
      chk("bp_ovf", g, 64'(ovf[g]), 64'd0);
      chk("bp_fbits", g, 64'(fbits[g]), 64'd32);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_ro_monitor.md
Name: spi_ro_monitor

Overview:
Passive, read-only SPI bus monitor and successor to the single-mode sniffer. It supports all four SPI modes, captures MOSI and MISO words of parametrised width and tracks frame boundaries. Completed words go into an on-chip FIFO that drains through a valid/ready stream toward the HPS DMA sink. It sits beside the power-supply SPI master and observes the bus without driving it.

Parameters:
- DWIDTH, 32: bits per captured word (2..64).
- BITCOUNTWIDTH, 12: width of the frame bit counter.
- CPOL, 1: clock idle level.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- FIFO_DEPTH, 8: entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- spi_ss_n  in  1  bus slave select, asynchronous.
- spi_sclk  in  1  bus clock, asynchronous.
- spi_mosi  in  1  bus MOSI, asynchronous.
- spi_miso  in  1  bus MISO, asynchronous.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  sink accepts head.
- out_master_data  out  DWIDTH  MOSI word, right-aligned.
- out_slave_data  out  DWIDTH  MISO word, right-aligned.
- out_nbits  out  $clog2(DWIDTH+1)  valid bits in entry (0..DWIDTH).
- out_last  out  1  entry closes a frame.
- frame_bits  out  BITCOUNTWIDTH  total bits of the last completed frame.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  occupied entries.
- overflow  out  1  sticky drop flag.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Reset: all outputs 0; FIFO empty. Internal state is WAIT_IDLE.
- Input synchronisation: every bus input passes a 2-flop synchroniser plus one history flop. Edges are detected from the history pair.
- Sample edge selection:
  - CPOL=0/CPHA=0 and CPOL=1/CPHA=1: SCLK rising.
  - CPOL=0/CPHA=1 and CPOL=1/CPHA=0: SCLK falling.
  - Latency from pin edge to sample is 3 clk cycles.
- State machine:
  - WAIT_IDLE: all edges ignored. Moves to IDLE once ss_n is synchronised high. This covers reset released mid-frame, where the partial frame is discarded.
  - IDLE: moves to ACTIVE on ss_n fall. Clears the shift registers, bit_cnt and frame_cnt.
  - ACTIVE: each sample shifts MOSI and MISO in MSB-first and increments bit_cnt. frame_cnt increments and saturates at 2^BITCOUNTWIDTH-1.
- Word completion: when bit_cnt reaches DWIDTH, push {master, slave, nbits=DWIDTH, last=0} and reset bit_cnt to 0 in the same cycle.
- Frame end (ACTIVE, ss_n rise) pushes exactly one entry with last=1, then returns to IDLE:
  - bit_cnt>0: push the partial word, right-aligned, with nbits=bit_cnt.
  - bit_cnt==0 and frame_cnt>0: push a marker with nbits=0 and data 0.
  - frame_cnt==0 (no clocks in frame): push nothing.
  - In the pushing cases, frame_bits<=frame_cnt.
- Simultaneous sample and ss_n rise in one cycle: the sample is taken first. If it completes a word, the full word is pushed that cycle. The nbits=0/last=1 marker is pushed the following cycle.
- FIFO behaviour:
  - First-word fall-through: a push at cycle N into an empty FIFO gives out_valid=1 at N+1.
  - A pop occurs when out_valid && out_ready.
  - Push is accepted only if fifo_level<FIFO_DEPTH at the start of the cycle, even if a pop happens that cycle.
  - A rejected push is dropped and sets overflow.
  - If overflow_clr and a drop occur in the same cycle, overflow stays 1.
  - Pointers wrap modulo FIFO_DEPTH.
- Output stability: outputs stay stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: SPI_RO_MONITOR_TIMESTAMP_EN.
- When defined: adds port out_timestamp (out, 32). A free-running 32-bit clk counter, wrapping modulo 2^32, is latched at ss_n fall (IDLE→ACTIVE). Every entry of that frame carries the latched value, reset value 0.
- When undefined: no port, no counter, and the FIFO entry width excludes the timestamp.

Test Plan:
- Base configuration: DWIDTH=8, CPOL=0, CPHA=0, out_ready=1. One frame: MOSI 0xA5, MISO 0x3C. Expect entry {A5,3C,nbits=8,last=0}, then {00,00,nbits=0,last=1}, and frame_bits=8.
- Partial frame: DWIDTH=8, 12 bits, MOSI 0xABC. Expect {AB,nbits=8,last=0}, then {0C,nbits=4,last=1}, and frame_bits=12.
- All modes: repeat the first test with CPOL/CPHA = 1/1, 0/1 and 1/0. Identical entries are expected. A wrong-edge model must fail.
- Overflow: FIFO_DEPTH=4, out_ready=0, frame of 6 bytes (7 pushes). Expect fifo_level=4, overflow=1, and the first 4 bytes retained in order. After draining and pulsing overflow_clr, expect overflow=0.
- Reset mid-frame: assert reset_n after 5 bits, release with ss_n still low, clock 8 more bits, raise ss_n. Expect no entries. The next full frame is captured normally.
- Backpressure: toggle out_ready every 3 cycles during 4 back-to-back 8-bit words. Expect no loss, no duplicates, and outputs held stable while stalled.
